memory_arbiter: RTL
===================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have parameters: STARVE_LIMIT, default 4, max consecutive fetch denials; BASE_ADDR, default 32'h80020000, instruction-space base and reset fetch target.
REQ-002 SHALL have ports, in order: clk in 1 clock; rst in 1 synchronous active-high reset.
REQ-003 SHALL have loader ports: ld_req in 1; ld_addr in 32; ld_wdata in 32; ld_size in 2; ld_done in 1 (load-complete pulse); ld_gnt out 1.
REQ-004 SHALL have data ports: dm_req in 1; dm_we in 1; dm_addr in 32; dm_wdata in 32; dm_size in 2; dm_gnt out 1; dm_rvalid out 1; dm_rdata out 32.
REQ-005 SHALL have fetch ports: if_req in 1; if_addr in 32; if_gnt out 1; if_rvalid out 1; if_rdata out 32; fetch_stall out 1.
REQ-006 SHALL have memory ports: address out 32; data_in out 32; write out 1; access_size out 2; data_out in 32.
REQ-007 SHALL use one clock, clk; reset rst is synchronous, active-high.

Function
REQ-008 SHALL use access_size encoding 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-009 SHALL implement states BOOT (reset state) and RUN.
REQ-010 In BOOT: only loader served; ld_gnt = ld_req, combinational; dm_gnt = if_gnt = 0; fetch_stall = 1.
REQ-011 BOOT -> RUN on the clock edge where ld_done = 1; a loader write in that same cycle SHALL still complete.
REQ-012 In RUN: ld_gnt = 0; fetch_stall = 0 except in a cycle where if_req = 1 and if_gnt = 0.
REQ-013 In RUN: exactly one grant per cycle at most; dm wins over if unless the starvation counter equals STARVE_LIMIT, then if wins.
REQ-014 Starvation counter SHALL increment in each cycle with if_req = 1 and if_gnt = 0, saturate at STARVE_LIMIT, and clear on if_gnt or if_req = 0.
REQ-015 Granted request SHALL drive address, data_in, write, access_size combinationally in the grant cycle.
REQ-016 Drive values: loader write = 1; dm write = dm_we; fetch write = 0 and access_size = 10.
REQ-017 Idle cycle (no grant) SHALL drive write = 0; address, data_in and access_size hold their last values.
REQ-018 Read grants (dm_we = 0, or fetch) SHALL register a one-bit source tag.
REQ-019 Read data SHALL return exactly one cycle after grant: the tagged requester's rvalid = 1 for one cycle, with its rdata = data_out in that cycle.
REQ-020 rvalid SHALL never assert for writes; back-to-back reads SHALL produce back-to-back rvalid in grant order.
REQ-021 dm_rdata and if_rdata SHALL hold their last captured value when rvalid = 0.
REQ-022 Requesters hold req and payload stable until gnt; the arbiter SHALL NOT buffer ungranted requests.
REQ-023 Reserved size 11 or misaligned word fetch (if_addr[1:0] != 0) SHALL still be granted; access_size is passed through unchanged.

Reset
REQ-024 On rst = 1 at a clk edge, the block SHALL enter BOOT.
REQ-025 Reset SHALL clear the starvation counter and the read tag valid bit.
REQ-026 Reset values: dm_rvalid = if_rvalid = 0; dm_rdata = if_rdata = 0; address = BASE_ADDR; data_in = 0; write = 0; access_size = 10.
REQ-027 Reset mid-read SHALL suppress the pending rvalid.

Structure
REQ-028 A shared package SHALL hold the access_size encoding constants, the state enum (BOOT, RUN), source-tag constants (SRC_DM, SRC_IF) and BASE_ADDR.
REQ-029 The fetch-priority and starvation logic SHALL be one sub-module, arb_starve_ctr (inputs if_req, if_gnt; output force_if).

Verification
REQ-030 After reset: ld_req = 1, ld_addr = 32'h80020000, ld_wdata = 8'hA5, ld_size = 00 -> same cycle write = 1, address = 32'h80020000; fetch_stall = 1; if_gnt = 0.
REQ-031 ld_done pulse with a concurrent loader write -> write completes; next cycle state is RUN, fetch_stall = 0 when no fetch request is pending.
REQ-032 In RUN, if_req = 1 at 32'h80020000, memory returns 32'h00000013 -> if_gnt in cycle N; if_rvalid = 1 and if_rdata = 32'h00000013 in cycle N+1.
REQ-033 dm_req and if_req both held high for 10 cycles -> dm granted 4 cycles, if granted in the 5th, pattern repeats; fetch_stall = 1 on every fetch-denied cycle.
REQ-034 Alternating dm read / fetch grants -> rvalid routed to the correct port each cycle; dm write -> no dm_rvalid.
REQ-035 rst asserted in the cycle after a dm read grant -> no dm_rvalid; state BOOT; outputs at REQ-026 values.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// Shared definitions for the memory arbiter slice.
//   - access_size encodings driven onto the memory port
//   - arbiter state enum (BOOT while the loader fills memory, RUN afterwards)
//   - one-bit source tags that route returning read data
//   - default instruction-space base / reset fetch target
package memory_arbiter_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic SRC_DM = 1'b0;
  localparam logic SRC_IF = 1'b1;

  localparam logic [31:0] BASE_ADDR = 32'h8002_0000;

endpackage

// File: rtl/arb_starve_ctr.sv
// Fetch starvation tracker.
// Counts consecutive cycles in which the fetch port asks but is not granted,
// saturating at STARVE_LIMIT. force_if tells the arbiter to give the next
// grant to fetch instead of data.
//   clk, rst  : clock, synchronous active-high reset
//   if_req    : fetch request this cycle
//   if_gnt    : fetch granted this cycle
//   force_if  : counter has reached STARVE_LIMIT
module arb_starve_ctr #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic if_gnt,
  output logic force_if
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt;

  // NOTE: clocked state is assigned with <= so every flop samples the
  // pre-edge values of its inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (!if_req || if_gnt) begin
      cnt <= '0;
    end else if (cnt != LIMIT) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign force_if = (cnt == LIMIT);

endmodule

// File: rtl/memory_arbiter.sv
// Single-port memory arbiter between a boot loader, a data port and an
// instruction-fetch port.
//   BOOT: only the loader is served (combinational grant), fetch is stalled.
//   RUN : one grant per cycle; data wins unless fetch has been starved for
//         STARVE_LIMIT cycles. Reads return one cycle after grant, routed by
//         a registered source tag.
// Ports:
//   clk, rst                               : clock, sync active-high reset
//   ld_req/ld_addr/ld_wdata/ld_size/ld_done: loader write channel, ld_gnt
//   dm_req/dm_we/dm_addr/dm_wdata/dm_size  : data channel, dm_gnt,
//                                            dm_rvalid/dm_rdata
//   if_req/if_addr                         : fetch channel, if_gnt,
//                                            if_rvalid/if_rdata, fetch_stall
//   address/data_in/write/access_size      : to memory; data_out from memory
module memory_arbiter #(
  parameter int          STARVE_LIMIT = 4,
  parameter logic [31:0] BASE_ADDR    = memory_arbiter_pkg::BASE_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_wdata,
  input  logic [1:0]  ld_size,
  input  logic        ld_done,
  output logic        ld_gnt,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [1:0]  dm_size,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        fetch_stall,
  output logic [31:0] address,
  output logic [31:0] data_in,
  output logic        write,
  output logic [1:0]  access_size,
  input  logic [31:0] data_out
);

  import memory_arbiter_pkg::*;

  state_t      state, next_state;
  logic        force_if;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic        rd_valid, rd_tag;
  logic [31:0] dm_rdata_q, if_rdata_q;

  arb_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_gnt   (if_gnt),
    .force_if (force_if)
  );

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a variable unassigned, which would infer a latch.
  always_comb begin
    next_state  = state;
    ld_gnt      = 1'b0;
    dm_gnt      = 1'b0;
    if_gnt      = 1'b0;
    fetch_stall = 1'b0;
    address     = addr_q;
    data_in     = wdata_q;
    access_size = size_q;
    write       = 1'b0;
    case (state)
      BOOT: begin
        ld_gnt      = ld_req;
        fetch_stall = 1'b1;
        if (ld_done) next_state = RUN;
        if (ld_req) begin
          address     = ld_addr;
          data_in     = ld_wdata;
          access_size = ld_size;
          write       = 1'b1;
        end
      end
      RUN: begin
        // Fetch only overrides data once it has been starved to the limit.
        if (dm_req && !(force_if && if_req)) begin
          dm_gnt      = 1'b1;
          address     = dm_addr;
          data_in     = dm_wdata;
          access_size = dm_size;
          write       = dm_we;
        end else if (if_req) begin
          if_gnt      = 1'b1;
          address     = if_addr;
          access_size = SIZE_WORD;
        end
        fetch_stall = if_req && !if_gnt;
      end
      default: next_state = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BOOT;
      addr_q     <= BASE_ADDR;
      wdata_q    <= '0;
      size_q     <= SIZE_WORD;
      rd_valid   <= 1'b0;
      rd_tag     <= SRC_DM;
      dm_rdata_q <= '0;
      if_rdata_q <= '0;
    end else begin
      state    <= next_state;
      // Idle cycles drive the held values, so capturing the bus every cycle
      // keeps them stable without a separate enable.
      addr_q   <= address;
      wdata_q  <= data_in;
      size_q   <= access_size;
      rd_valid <= (dm_gnt && !dm_we) || if_gnt;
      rd_tag   <= if_gnt ? SRC_IF : SRC_DM;
      if (dm_rvalid) dm_rdata_q <= data_out;
      if (if_rvalid) if_rdata_q <= data_out;
    end
  end

  // Gating with rst drops a read that was in flight when reset arrived.
  assign dm_rvalid = rd_valid && (rd_tag == SRC_DM) && !rst;
  assign if_rvalid = rd_valid && (rd_tag == SRC_IF) && !rst;
  assign dm_rdata  = dm_rvalid ? data_out : dm_rdata_q;
  assign if_rdata  = if_rvalid ? data_out : if_rdata_q;

endmodule
